// File: rtl/pwm_capture.sv
// PWM receiver: measures rising-edge-to-rising-edge period and high time, flags DC
// inputs via timeout, and tracks the breathing envelope direction with peak strobes.
module pwm_capture #(
    parameter int TIMEOUT    = 512,
    parameter int MIN_PERIOD = 4,
    parameter int CNT_W      = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_in,
    output logic [7:0]       duty,
    output logic             duty_valid,
    output logic [CNT_W-1:0] period_cnt,
    output logic             dc_level,
    output logic [1:0]       trend,
    output logic             peak
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        DC      = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] MIN_C      = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] DUTY_MAX_C = CNT_W'(8'hFF);
    localparam logic [1:0]       TREND_FLAT = 2'b00;
    localparam logic [1:0]       TREND_UP   = 2'b01;
    localparam logic [1:0]       TREND_DOWN = 2'b10;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            sat_inc = v;
        end else begin
            sat_inc = v + CNT_ONE;
        end
    endfunction

    function automatic logic [7:0] sat_duty(input logic [CNT_W-1:0] v);
        if (v > DUTY_MAX_C) begin
            sat_duty = 8'hFF;
        end else begin
            sat_duty = v[7:0];
        end
    endfunction

    function automatic logic [1:0] dir_of(input logic [7:0] cur, input logic [7:0] prev);
        if (cur > prev) begin
            dir_of = TREND_UP;
        end else if (cur < prev) begin
            dir_of = TREND_DOWN;
        end else begin
            dir_of = TREND_FLAT;
        end
    endfunction

    logic             sync_meta_r;
    logic             sync_r;
    logic             sync_prev_r;
    logic [CNT_W-1:0] per_cnt_r;
    logic [CNT_W-1:0] hi_cnt_r;
    state_t           state_r;
    logic [7:0]       prev_duty_r;
    logic             prev_valid_r;
    logic [1:0]       last_dir_r;

    logic       rise_s;
    logic       timeout_s;
    logic       long_enough_s;
    logic       meas_strobe_s;
    logic       dc_strobe_s;
    logic       strobe_s;
    logic       restart_s;
    logic [7:0] new_duty_s;
    logic [1:0] new_dir_s;

    assign rise_s        = sync_r & ~sync_prev_r;
    assign timeout_s     = (per_cnt_r >= TIMEOUT_C);
    assign long_enough_s = (per_cnt_r >= MIN_C);

    // Decide per cycle whether counters restart and which strobe (if any) fires.
    always_comb begin
        meas_strobe_s = 1'b0;
        dc_strobe_s   = 1'b0;
        restart_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (rise_s) begin
                    restart_s = 1'b1;
                end else if (timeout_s) begin
                    dc_strobe_s = 1'b1;
                end else begin
                    restart_s = 1'b0;
                end
            end
            MEASURE: begin
                if (rise_s && long_enough_s) begin
                    meas_strobe_s = 1'b1;
                    restart_s     = 1'b1;
                end else if (!rise_s && timeout_s) begin
                    dc_strobe_s = 1'b1;
                end else begin
                    restart_s = 1'b0;
                end
            end
            DC: begin
                if (rise_s) begin
                    restart_s = 1'b1;
                end else begin
                    restart_s = 1'b0;
                end
            end
            default: begin
                restart_s = 1'b0;
            end
        endcase
        strobe_s   = meas_strobe_s | dc_strobe_s;
        new_duty_s = meas_strobe_s ? sat_duty(hi_cnt_r) : (sync_r ? 8'hFF : 8'h00);
        new_dir_s  = dir_of(new_duty_s, prev_duty_r);
    end

    // Two-stage synchronizer plus the edge-detect history bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta_r <= 1'b0;
            sync_r      <= 1'b0;
            sync_prev_r <= 1'b0;
        end else begin
            sync_meta_r <= pwm_in;
            sync_r      <= sync_meta_r;
            sync_prev_r <= sync_r;
        end
    end

    // Measurement FSM with its counters and registered measurement outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            per_cnt_r  <= {CNT_W{1'b0}};
            hi_cnt_r   <= {CNT_W{1'b0}};
            duty       <= 8'h00;
            duty_valid <= 1'b0;
            period_cnt <= {CNT_W{1'b0}};
            dc_level   <= 1'b0;
        end else begin
            per_cnt_r  <= restart_s ? CNT_ONE : sat_inc(per_cnt_r);
            hi_cnt_r   <= restart_s ? CNT_ONE : (sync_r ? sat_inc(hi_cnt_r) : hi_cnt_r);
            duty_valid <= strobe_s;
            if (strobe_s) begin
                duty <= new_duty_s;
            end else begin
                duty <= duty;
            end
            case (state_r)
                IDLE, MEASURE: begin
                    if (rise_s) begin
                        state_r <= MEASURE;
                        if (meas_strobe_s) begin
                            period_cnt <= per_cnt_r;
                        end
                    end else if (dc_strobe_s) begin
                        state_r    <= DC;
                        period_cnt <= {CNT_W{1'b0}};
                        dc_level   <= 1'b1;
                    end else begin
                        state_r <= state_r;
                    end
                end
                DC: begin
                    if (rise_s) begin
                        state_r  <= MEASURE;
                        dc_level <= 1'b0;
                    end else begin
                        state_r <= DC;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Envelope direction; the last non-flat direction is kept so flat samples
    // between a rise and a fall still produce a peak.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trend        <= TREND_FLAT;
            peak         <= 1'b0;
            prev_duty_r  <= 8'h00;
            prev_valid_r <= 1'b0;
            last_dir_r   <= TREND_FLAT;
        end else begin
            peak <= 1'b0;
            if (strobe_s) begin
                prev_duty_r <= new_duty_s;
                if (!prev_valid_r) begin
                    trend        <= TREND_FLAT;
                    prev_valid_r <= 1'b1;
                    last_dir_r   <= TREND_FLAT;
                end else begin
                    trend <= new_dir_s;
                    peak  <= (last_dir_r == TREND_UP) && (new_dir_s == TREND_DOWN);
                    if (new_dir_s != TREND_FLAT) begin
                        last_dir_r <= new_dir_s;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: periods, trend/peak, DC timeout, restart, glitch, reset.
module tb_pwm_capture;

    logic       clk;
    logic       rst_n;
    logic       pwm_in;
    logic [7:0] duty;
    logic       duty_valid;
    logic [9:0] period_cnt;
    logic       dc_level;
    logic [1:0] trend;
    logic       peak;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int rise_cyc = 0;
    int peak_cnt = 0;

    logic [7:0] q_duty[$];
    logic [9:0] q_per[$];
    logic [1:0] q_trend[$];
    logic       q_peak[$];
    logic       q_dc[$];
    int         q_lat[$];

    pwm_capture #(.TIMEOUT(512), .MIN_PERIOD(4), .CNT_W(10)) dut (
        .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in), .duty(duty), .duty_valid(duty_valid),
        .period_cnt(period_cnt), .dc_level(dc_level), .trend(trend), .peak(peak)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every strobe with its latency from the last raw rising edge.
    always @(negedge clk) begin
        if (duty_valid) begin
            q_duty.push_back(duty);
            q_per.push_back(period_cnt);
            q_trend.push_back(trend);
            q_peak.push_back(peak);
            q_dc.push_back(dc_level);
            q_lat.push_back(cyc - rise_cyc);
        end
        if (peak) peak_cnt = peak_cnt + 1;
    end

    task automatic set_pwm(input logic v);
        if (v && !pwm_in) rise_cyc = cyc;
        pwm_in = v;
    endtask

    task automatic drive_level(input logic v, input int n);
        set_pwm(v);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_period(input int per, input int hi);
        drive_level(1'b1, hi);
        drive_level(1'b0, per - hi);
    endtask

    task automatic test_reset;
        checks++; if (duty !== 8'h00) begin failures++; $display("FAIL reset_duty got=%h exp=00", duty); end
        checks++; if (duty_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", duty_valid); end
        checks++; if (period_cnt !== 10'd0) begin failures++; $display("FAIL reset_period got=%0d exp=0", period_cnt); end
        checks++; if (dc_level !== 1'b0) begin failures++; $display("FAIL reset_dc got=%b exp=0", dc_level); end
        checks++; if (trend !== 2'b00) begin failures++; $display("FAIL reset_trend got=%b exp=00", trend); end
        checks++; if (peak !== 1'b0) begin failures++; $display("FAIL reset_peak got=%b exp=0", peak); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic;
        int base;
        base = q_duty.size();
        repeat (3) drive_period(256, 64);
        checks++;
        if (q_duty.size() - base !== 2) begin
            failures++; $display("FAIL basic_count got=%0d exp=2", q_duty.size() - base);
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++; if (q_duty[base+i] !== 8'h40) begin failures++; $display("FAIL basic_duty[%0d] got=%h exp=40", i, q_duty[base+i]); end
                checks++; if (q_per[base+i] !== 10'd256) begin failures++; $display("FAIL basic_period[%0d] got=%0d exp=256", i, q_per[base+i]); end
                checks++; if (q_trend[base+i] !== 2'b00) begin failures++; $display("FAIL basic_trend[%0d] got=%b exp=00", i, q_trend[base+i]); end
                checks++; if (q_peak[base+i] !== 1'b0) begin failures++; $display("FAIL basic_peak[%0d] got=%b exp=0", i, q_peak[base+i]); end
                checks++; if (q_lat[base+i] !== 3) begin failures++; $display("FAIL basic_latency[%0d] got=%0d exp=3", i, q_lat[base+i]); end
            end
        end
    endtask

    task automatic test_trend;
        int base;
        int pk0;
        logic [7:0] exp_d [4] = '{8'h40, 8'h50, 8'h60, 8'h46};
        logic [1:0] exp_t [4] = '{2'b00, 2'b01, 2'b01, 2'b10};
        logic       exp_p [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        base = q_duty.size();
        pk0  = peak_cnt;
        drive_period(256, 80);
        drive_period(256, 96);
        drive_period(256, 70);
        drive_period(256, 64);
        checks++;
        if (q_duty.size() - base !== 4) begin
            failures++; $display("FAIL trend_count got=%0d exp=4", q_duty.size() - base);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++; if (q_duty[base+i] !== exp_d[i]) begin failures++; $display("FAIL trend_duty[%0d] got=%h exp=%h", i, q_duty[base+i], exp_d[i]); end
                checks++; if (q_trend[base+i] !== exp_t[i]) begin failures++; $display("FAIL trend_dir[%0d] got=%b exp=%b", i, q_trend[base+i], exp_t[i]); end
                checks++; if (q_peak[base+i] !== exp_p[i]) begin failures++; $display("FAIL trend_peak[%0d] got=%b exp=%b", i, q_peak[base+i], exp_p[i]); end
            end
        end
        checks++; if (peak_cnt - pk0 !== 1) begin failures++; $display("FAIL trend_peak_total got=%0d exp=1", peak_cnt - pk0); end
    endtask

    task automatic test_dc_high;
        int base;
        drive_level(1'b1, 10);
        base = q_duty.size();
        drive_level(1'b1, 590);
        checks++;
        if (q_duty.size() - base !== 1) begin
            failures++; $display("FAIL dchi_count got=%0d exp=1", q_duty.size() - base);
        end else begin
            checks++; if (q_duty[base] !== 8'hFF) begin failures++; $display("FAIL dchi_duty got=%h exp=ff", q_duty[base]); end
            checks++; if (q_per[base] !== 10'd0) begin failures++; $display("FAIL dchi_period got=%0d exp=0", q_per[base]); end
            checks++; if (q_dc[base] !== 1'b1) begin failures++; $display("FAIL dchi_dc got=%b exp=1", q_dc[base]); end
            checks++; if (q_trend[base] !== 2'b01) begin failures++; $display("FAIL dchi_trend got=%b exp=01", q_trend[base]); end
        end
        checks++; if (dc_level !== 1'b1) begin failures++; $display("FAIL dchi_hold got=%b exp=1", dc_level); end
    endtask

    task automatic test_dc_low;
        int base;
        drive_level(1'b0, 10);
        drive_period(256, 64);
        drive_period(256, 64);
        base = q_duty.size();
        drive_level(1'b0, 600);
        checks++;
        if (q_duty.size() - base !== 1) begin
            failures++; $display("FAIL dclo_count got=%0d exp=1", q_duty.size() - base);
        end else begin
            checks++; if (q_duty[base] !== 8'h00) begin failures++; $display("FAIL dclo_duty got=%h exp=00", q_duty[base]); end
            checks++; if (q_per[base] !== 10'd0) begin failures++; $display("FAIL dclo_period got=%0d exp=0", q_per[base]); end
            checks++; if (q_dc[base] !== 1'b1) begin failures++; $display("FAIL dclo_dc got=%b exp=1", q_dc[base]); end
            checks++; if (q_trend[base] !== 2'b10) begin failures++; $display("FAIL dclo_trend got=%b exp=10", q_trend[base]); end
            checks++; if (q_peak[base] !== 1'b0) begin failures++; $display("FAIL dclo_peak got=%b exp=0", q_peak[base]); end
        end
    endtask

    task automatic test_restart;
        int base;
        base = q_duty.size();
        set_pwm(1'b1);
        repeat (2) @(negedge clk);
        checks++; if (dc_level !== 1'b1) begin failures++; $display("FAIL restart_dc_before got=%b exp=1", dc_level); end
        @(negedge clk);
        checks++; if (dc_level !== 1'b0) begin failures++; $display("FAIL restart_dc_after got=%b exp=0", dc_level); end
        repeat (125) @(negedge clk);
        drive_level(1'b0, 128);
        checks++; if (q_duty.size() - base !== 0) begin failures++; $display("FAIL restart_no_strobe got=%0d exp=0", q_duty.size() - base); end
        base = q_duty.size();
        drive_period(256, 128);
        checks++;
        if (q_duty.size() - base !== 1) begin
            failures++; $display("FAIL restart_count got=%0d exp=1", q_duty.size() - base);
        end else begin
            checks++; if (q_duty[base] !== 8'h80) begin failures++; $display("FAIL restart_duty got=%h exp=80", q_duty[base]); end
            checks++; if (q_per[base] !== 10'd256) begin failures++; $display("FAIL restart_period got=%0d exp=256", q_per[base]); end
            checks++; if (q_dc[base] !== 1'b0) begin failures++; $display("FAIL restart_dc got=%b exp=0", q_dc[base]); end
            checks++; if (q_trend[base] !== 2'b01) begin failures++; $display("FAIL restart_trend got=%b exp=01", q_trend[base]); end
        end
    endtask

    task automatic test_glitch;
        int base;
        base = q_duty.size();
        drive_level(1'b1, 1);
        drive_level(1'b0, 1);
        drive_level(1'b1, 62);
        drive_level(1'b0, 192);
        checks++; if (q_duty.size() - base !== 1) begin failures++; $display("FAIL glitch_strobes got=%0d exp=1", q_duty.size() - base); end
        base = q_duty.size();
        drive_period(256, 64);
        checks++;
        if (q_duty.size() - base !== 1) begin
            failures++; $display("FAIL glitch_count got=%0d exp=1", q_duty.size() - base);
        end else begin
            checks++; if (q_duty[base] !== 8'h3F) begin failures++; $display("FAIL glitch_duty got=%h exp=3f", q_duty[base]); end
            checks++; if (q_per[base] !== 10'd256) begin failures++; $display("FAIL glitch_period got=%0d exp=256", q_per[base]); end
        end
    endtask

    task automatic test_reset_mid;
        int base;
        drive_level(1'b1, 30);
        drive_level(1'b0, 20);
        rst_n = 1'b0;
        #1;
        checks++; if (duty !== 8'h00) begin failures++; $display("FAIL midrst_duty got=%h exp=00", duty); end
        checks++; if (period_cnt !== 10'd0) begin failures++; $display("FAIL midrst_period got=%0d exp=0", period_cnt); end
        checks++; if (trend !== 2'b00) begin failures++; $display("FAIL midrst_trend got=%b exp=00", trend); end
        checks++; if (dc_level !== 1'b0 || duty_valid !== 1'b0 || peak !== 1'b0) begin
            failures++; $display("FAIL midrst_flags got=%b%b%b exp=000", dc_level, duty_valid, peak);
        end
        @(negedge clk);
        rst_n = 1'b1;
        base = q_duty.size();
        drive_period(256, 64);
        checks++; if (q_duty.size() - base !== 0) begin failures++; $display("FAIL midrst_first_edge got=%0d exp=0", q_duty.size() - base); end
        drive_period(256, 64);
        checks++;
        if (q_duty.size() - base !== 1) begin
            failures++; $display("FAIL midrst_count got=%0d exp=1", q_duty.size() - base);
        end else begin
            checks++; if (q_duty[base] !== 8'h40) begin failures++; $display("FAIL midrst_meas_duty got=%h exp=40", q_duty[base]); end
            checks++; if (q_per[base] !== 10'd256) begin failures++; $display("FAIL midrst_meas_period got=%0d exp=256", q_per[base]); end
            checks++; if (q_trend[base] !== 2'b00) begin failures++; $display("FAIL midrst_meas_trend got=%b exp=00", q_trend[base]); end
            checks++; if (q_lat[base] !== 3) begin failures++; $display("FAIL midrst_latency got=%0d exp=3", q_lat[base]); end
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        test_reset;
        test_basic;
        test_trend;
        test_dc_high;
        test_dc_low;
        test_restart;
        test_glitch;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
